pc_stack: RTL

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack.sv | 79 +++++++
 1 files changed

// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for call/ret.
// Overflow and underflow are sticky until reset; a full or empty stack never wedges the pc.
module pc_stack #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      STEP        = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic                               load_i,
    input  logic                               call_i,
    input  logic                               ret_i,
    input  logic [WIDTH-1:0]                   im_i,
    output logic [WIDTH-1:0]                   pc_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic                               ovf_o,
    output logic                               unf_o
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [WIDTH-1:0] pc_inc;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic             push;

    assign pc_inc   = pc_o + WIDTH'(STEP);
    assign full_o   = (depth_o == DW'(STACK_DEPTH));
    assign empty_o  = (depth_o == '0);
    assign push_idx = IW'(depth_o);
    assign top_idx  = IW'(depth_o - DW'(1));

    // ret outranks call, so a push only happens on a clean, non-full call
    assign push = en_i && !rst_i && !ret_i && call_i && !full_o;

    // Stack memory is never reset; depth_o alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o    <= RESET_VAL;
            depth_o <= '0;
            ovf_o   <= 1'b0;
            unf_o   <= 1'b0;
        end else if (en_i) begin
            if (ret_i) begin
                if (!empty_o) begin
                    pc_o    <= stack_q[top_idx];
                    depth_o <= depth_o - DW'(1);
                end else begin
                    pc_o  <= pc_inc;
                    unf_o <= 1'b1;
                end
            end else if (call_i) begin
                pc_o <= im_i;
                if (!full_o) begin
                    depth_o <= depth_o + DW'(1);
                end else begin
                    ovf_o <= 1'b1;
                end
            end else if (load_i) begin
                pc_o <= im_i;
            end else begin
                pc_o <= pc_inc;
            end
        end
    end

endmodule
